// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the fp_mult result path: status bit map,
// the packed result word, and the buffer occupancy states.
package fp_mult_pkg;

  localparam int unsigned ZERO_BIT    = 0;
  localparam int unsigned INF_BIT     = 1;
  localparam int unsigned NAN_BIT     = 2;
  localparam int unsigned TINY_BIT    = 3;
  localparam int unsigned HUGE_BIT    = 4;
  localparam int unsigned INEXACT_BIT = 5;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef struct packed {
    logic [31:0] z;
    logic [7:0]  status;
  } fp_result_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/fp_mult_result_buffer_if.sv
// Producer/consumer handshake bundle around the fp_mult result buffer.
interface fp_mult_result_buffer_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_z;
  logic [7:0]  in_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [7:0]  out_status;

  modport master (
    output in_valid, in_z, in_status, out_ready,
    input  in_ready, out_valid, out_z, out_status
  );

  modport slave (
    input  in_valid, in_z, in_status, out_ready,
    output in_ready, out_valid, out_z, out_status
  );

endinterface

// File: rtl/fp_result_fifo.sv
// Small result FIFO: pointers, occupancy tracking and the valid/ready handshake.
// The head word is kept in its own register so the output never sees stale storage.
module fp_result_fifo
  import fp_mult_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  fp_result_t             push_data,
  output logic                   pop_valid,
  input  logic                   pop_ready,
  output fp_result_t             pop_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  fp_result_t    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_ptr_nxt_s;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_nxt_s;
  fifo_state_t   state_r;
  fp_result_t    head_r;
  fp_result_t    head_nxt_s;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          push_s;
  logic          pop_s;

  assign push_s     = push_valid && in_ready_r;
  assign pop_s      = out_valid_r && pop_ready;
  assign push_ready = in_ready_r;
  assign pop_valid  = out_valid_r;
  assign pop_data   = head_r;
  assign level      = level_r;

  // Next read pointer, occupancy and the word that will sit at the head.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    level_nxt_s  = level_r;
    head_nxt_s   = '0;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
    // A push landing exactly on the next head slot is not in storage yet.
    if (level_nxt_s == '0) begin
      head_nxt_s = '0;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = push_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Entry storage; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy state machine and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      head_r      <= '0;
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      head_r   <= head_nxt_s;
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            state_r     <= ST_PARTIAL;
            out_valid_r <= 1'b1;
          end
        end
        ST_PARTIAL: begin
          if (push_s && !pop_s && (level_r == LW'(DEPTH - 1))) begin
            state_r    <= ST_FULL;
            in_ready_r <= 1'b0;
          end else if (pop_s && !push_s && (level_r == LW'(1))) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            state_r    <= ST_PARTIAL;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fp_mult_result_buffer.sv
// Buffers fp_mult results for a back-pressuring consumer and keeps sticky
// exception flags plus saturating result/NaN counters for inspection.
module fp_mult_result_buffer
  import fp_mult_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  fp_mult_result_buffer_if.slave  bus,
  input  logic                    flags_clr,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              sticky_flags,
  output logic [CNT_W-1:0]        result_cnt,
  output logic [CNT_W-1:0]        nan_cnt
);

  fp_result_t       push_data_s;
  fp_result_t       pop_data_s;
  logic             push_s;
  logic [7:0]       sticky_r;
  logic [CNT_W-1:0] result_cnt_r;
  logic [CNT_W-1:0] nan_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign push_data_s    = '{z: bus.in_z, status: bus.in_status};
  assign push_s         = bus.in_valid && bus.in_ready;
  assign bus.out_z      = pop_data_s.z;
  assign bus.out_status = pop_data_s.status;
  assign sticky_flags   = sticky_r;
  assign result_cnt     = result_cnt_r;
  assign nan_cnt        = nan_cnt_r;

  fp_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_data  (push_data_s),
    .pop_valid  (bus.out_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (pop_data_s),
    .level      (level)
  );

  // Sticky flags and counters; a clear takes effect before a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_r     <= 8'h00;
      result_cnt_r <= '0;
      nan_cnt_r    <= '0;
    end else if (flags_clr) begin
      sticky_r     <= push_s ? bus.in_status : 8'h00;
      result_cnt_r <= push_s ? CNT_W'(1) : '0;
      nan_cnt_r    <= push_s ? CNT_W'(bus.in_status[NAN_BIT]) : '0;
    end else if (push_s) begin
      sticky_r     <= sticky_r | bus.in_status;
      result_cnt_r <= sat_inc(result_cnt_r);
      nan_cnt_r    <= bus.in_status[NAN_BIT] ? sat_inc(nan_cnt_r) : nan_cnt_r;
    end else begin
      sticky_r     <= sticky_r;
      result_cnt_r <= result_cnt_r;
      nan_cnt_r    <= nan_cnt_r;
    end
  end

endmodule

// File: tb/tb_fp_mult_result_buffer.sv
// Self-checking bench: a table of per-cycle vectors with expected status, a
// scoreboard queue for FIFO data order, and hand sequences for reset and saturation.
module tb_fp_mult_result_buffer;
  import fp_mult_pkg::*;

  logic clk;
  logic rst;
  logic flags_clr;
  logic flags_clr2;
  logic [2:0]  level;
  logic [7:0]  sticky_flags;
  logic [15:0] result_cnt;
  logic [15:0] nan_cnt;
  logic [2:0]  level2;
  logic [7:0]  sticky2;
  logic [3:0]  rc2;
  logic [3:0]  nc2;

  int checks = 0;
  int errors = 0;
  fp_result_t exp_q[$];

  fp_mult_result_buffer_if bus ();
  fp_mult_result_buffer_if bus2 ();

  fp_mult_result_buffer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flags_clr(flags_clr), .level(level),
    .sticky_flags(sticky_flags), .result_cnt(result_cnt), .nan_cnt(nan_cnt)
  );

  fp_mult_result_buffer #(.DEPTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2), .flags_clr(flags_clr2), .level(level2),
    .sticky_flags(sticky2), .result_cnt(rc2), .nan_cnt(nc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] z;
    logic [7:0]  st;
    logic        ordy;
    logic        clr;
    logic [2:0]  lvl;
    logic        irdy;
    logic        ovld;
    logic [7:0]  sticky;
    logic [15:0] rc;
    logic [15:0] nc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard bookkeeping for the handshakes about to fire, then one clock.
  task automatic step();
    fp_result_t e;
    if (bus.in_valid && bus.in_ready) exp_q.push_back('{z: bus.in_z, status: bus.in_status});
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pop_z", bus.out_z, e.z);
        chk("pop_status", {24'h0, bus.out_status}, {24'h0, e.status});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] z, input logic [7:0] st,
                       input logic ordy, input logic clr);
    bus.in_valid  = iv;
    bus.in_z      = z;
    bus.in_status = st;
    bus.out_ready = ordy;
    flags_clr     = clr;
  endtask

  initial begin
    // inputs, then expected state after the edge
    vecs[0]  = '{1'b1, 32'h4000_0000, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 8'h00, 16'd1, 16'd0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 16'd1, 16'd0};
    vecs[2]  = '{1'b1, 32'h3F80_0000, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 8'h00, 16'd2, 16'd0};
    vecs[3]  = '{1'b1, 32'hC080_0000, 8'h00, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 8'h00, 16'd3, 16'd0};
    vecs[4]  = '{1'b1, PINF,          8'h02, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 8'h02, 16'd4, 16'd0};
    vecs[5]  = '{1'b1, QNAN,          8'h04, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 8'h06, 16'd5, 16'd1};
    vecs[6]  = '{1'b1, 32'h0000_0000, 8'h01, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 8'h06, 16'd5, 16'd1};
    vecs[7]  = '{1'b1, 32'h0000_0000, 8'h01, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 8'h06, 16'd5, 16'd1};
    vecs[8]  = '{1'b1, 32'h0000_0000, 8'h01, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 8'h07, 16'd6, 16'd1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 8'h07, 16'd6, 16'd1};
    vecs[10] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 8'h07, 16'd6, 16'd1};
    vecs[11] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h07, 16'd6, 16'd1};
    vecs[12] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h07, 16'd6, 16'd1};
    vecs[13] = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 16'd0, 16'd0};
    vecs[14] = '{1'b1, PINF,          8'h02, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 8'h02, 16'd1, 16'd0};
    vecs[15] = '{1'b1, QNAN,          8'h04, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 8'h06, 16'd2, 16'd1};
    vecs[16] = '{1'b1, 32'h3F80_0000, 8'h20, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 8'h20, 16'd1, 16'd0};
    vecs[17] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 8'h20, 16'd1, 16'd0};
    vecs[18] = '{1'b1, 32'h4040_0000, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 8'h20, 16'd2, 16'd0};
    vecs[19] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 8'h20, 16'd2, 16'd0};
    vecs[20] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h20, 16'd2, 16'd0};

    rst = 1'b1;
    flags_clr2 = 1'b0;
    drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    bus2.in_valid  = 1'b0;
    bus2.in_z      = 32'h0;
    bus2.in_status = 8'h00;
    bus2.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", {29'h0, level}, 32'd0);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_out_z", bus.out_z, 32'h0);
    chk("rst_sticky", {24'h0, sticky_flags}, 32'h0);
    chk("rst_cnt", {16'h0, result_cnt}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].z, vecs[i].st, vecs[i].ordy, vecs[i].clr);
      step();
      if (i == 0) chk("v0_out_z", bus.out_z, 32'h4000_0000);
      chk($sformatf("v%0d_level", i), {29'h0, level}, {29'h0, vecs[i].lvl});
      chk($sformatf("v%0d_in_ready", i), {31'h0, bus.in_ready}, {31'h0, vecs[i].irdy});
      chk($sformatf("v%0d_out_valid", i), {31'h0, bus.out_valid}, {31'h0, vecs[i].ovld});
      chk($sformatf("v%0d_sticky", i), {24'h0, sticky_flags}, {24'h0, vecs[i].sticky});
      chk($sformatf("v%0d_result_cnt", i), {16'h0, result_cnt}, {16'h0, vecs[i].rc});
      chk($sformatf("v%0d_nan_cnt", i), {16'h0, nan_cnt}, {16'h0, vecs[i].nc});
    end
    chk("sb_drained", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a cycle at level 3.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hA000_0001 + 32'(k), 8'h10, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_level", {29'h0, level}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("async_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("async_rst_level", {29'h0, level}, 32'd0);
    chk("async_rst_sticky", {24'h0, sticky_flags}, 32'h0);
    chk("async_rst_out_z", bus.out_z, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("post_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    drive(1'b1, 32'h1234_5678, 8'h20, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_head", bus.out_z, 32'h1234_5678);
    chk("post_rst_cnt", {16'h0, result_cnt}, 32'd1);
    step();
    chk("post_rst_empty", {31'h0, bus.out_valid}, 32'd0);

    // Saturation on the 4-bit counter build: 17 NaN pushes.
    bus2.in_valid  = 1'b1;
    bus2.in_z      = QNAN;
    bus2.in_status = 8'h04;
    bus2.out_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk($sformatf("sat_rc_%0d", k), {28'h0, rc2}, (k > 15) ? 32'd15 : 32'(k));
    end
    bus2.in_valid = 1'b0;
    step();
    chk("sat_rc_hold", {28'h0, rc2}, 32'd15);
    chk("sat_nc_hold", {28'h0, nc2}, 32'd15);
    chk("sat_sticky", {24'h0, sticky2}, 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
